// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: issues sequential imem requests ahead of decode and
// buffers returned words in an in-order queue. Define FETCH_PERF_EN to add perf counters.
module fetch_prefetch_queue #(
   parameter int unsigned          XLEN     = 32,
   parameter int unsigned          DEPTH    = 4,
   parameter logic [XLEN-1:0]      RESET_PC = '0
) (
   input  logic            CLK,
   input  logic            RSTa,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [31:0]     id_instr,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc_plus4
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_flushed
`endif
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   typedef logic [CW-1:0] cnt_t;

   logic [31:0]     instr_mem [DEPTH];
   logic [XLEN-1:0] pc_mem    [DEPTH];

   logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
   cnt_t            count_q, count_d;
   cnt_t            inflight_q, inflight_d;
   cnt_t            discard_q, discard_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;

   logic            grant, rsp_ok, push, pop, drop;
   logic [CW:0]     occupancy;
   logic [XLEN-1:0] redirect_target;

   // Credit counts queued entries plus live (non-discarded) requests, one bit wider so it never wraps.
   always_comb begin
      occupancy       = {1'b0, count_q} + {1'b0, inflight_q} - {1'b0, discard_q};
      redirect_target = redirect_pc & ~XLEN'(3);
      imem_req        = !RSTa && !redirect_valid && (occupancy < DEPTH_W);
      imem_addr       = fetch_pc_q;
      grant           = imem_req && imem_gnt;
      rsp_ok          = imem_rvalid && (inflight_q != '0);
      push            = rsp_ok && (discard_q == '0) && !redirect_valid;
      drop            = rsp_ok && !push;
      id_valid        = (count_q != '0);
      pop             = id_valid && id_ready;
   end

   // NOTE: every variable gets a default at the top of always_comb so no latch can be inferred.
   always_comb begin
      inflight_d = inflight_q + cnt_t'(grant) - cnt_t'(rsp_ok);
      discard_d  = discard_q;
      count_d    = count_q + cnt_t'(push) - cnt_t'(pop);
      head_d     = head_q;
      tail_d     = tail_q;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;

      if (rsp_ok && (discard_q != '0)) discard_d = discard_q - cnt_t'(1);
      if (pop)   head_d     = head_q + PW'(1);
      if (push)  tail_d     = tail_q + PW'(1);
      if (grant) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push)  resp_pc_d  = resp_pc_q + XLEN'(4);

      if (redirect_valid) begin
         discard_d  = inflight_d;
         count_d    = '0;
         head_d     = '0;
         tail_d     = '0;
         fetch_pc_d = redirect_target;
         resp_pc_d  = redirect_target;
      end
   end

   always_ff @(posedge CLK) begin
      if (RSTa) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         inflight_q <= '0;
         discard_q  <= '0;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
      end
   end

   // NOTE: the entry storage is deliberately not reset; id_* are gated by id_valid instead.
   always_ff @(posedge CLK) begin
      if (push) begin
         instr_mem[tail_q] <= imem_rdata;
         pc_mem[tail_q]    <= resp_pc_q;
      end
   end

   always_comb begin
      id_instr    = '0;
      id_pc       = '0;
      id_pc_plus4 = '0;
      if (id_valid) begin
         id_instr    = instr_mem[head_q];
         id_pc       = pc_mem[head_q];
         id_pc_plus4 = pc_mem[head_q] + XLEN'(4);
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_flushed_q, perf_flushed_d;
   logic [31:0] flushed_inc;
   logic [32:0] fetched_sum, flushed_sum;

   // Entries popped in the redirect cycle reached ID, so only the remainder counts as flushed.
   always_comb begin
      flushed_inc    = 32'(drop);
      if (redirect_valid) flushed_inc = flushed_inc + 32'(count_q - cnt_t'(pop));
      fetched_sum    = {1'b0, perf_fetched_q} + 33'(pop);
      flushed_sum    = {1'b0, perf_flushed_q} + {1'b0, flushed_inc};
      perf_fetched_d = fetched_sum[32] ? '1 : fetched_sum[31:0];
      perf_flushed_d = flushed_sum[32] ? '1 : flushed_sum[31:0];
   end

   always_ff @(posedge CLK) begin
      if (RSTa) begin
         perf_fetched_q <= '0;
         perf_flushed_q <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_flushed_q <= perf_flushed_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_flushed = perf_flushed_q;
`endif

   ap_no_orphan_rsp: assert property (@(posedge CLK) disable iff (RSTa)
      imem_rvalid |-> (inflight_q != '0));
   ap_no_push_full: assert property (@(posedge CLK) disable iff (RSTa)
      push |-> (count_q != cnt_t'(DEPTH)));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue: directed fetch/redirect/reset scenarios,
// an in-order memory model with programmable latency, and a pop-side monitor.
module tb_fetch_prefetch_queue;

   logic        CLK = 1'b0;
   logic        RSTa;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_flushed;
`endif

   fetch_prefetch_queue #(
      .XLEN     (32),
      .DEPTH    (4),
      .RESET_PC (32'h0000_0100)
   ) dut (
      .CLK            (CLK),
      .RSTa           (RSTa),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_pc_plus4    (id_pc_plus4)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_flushed   (perf_flushed)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] plus4;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   int          n_total = 0;
   int          n_bad   = 0;
   int          cyc     = 0;
   int          lat     = 1;
   int          grant_cnt = 0;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic [31:0] plus4);
      exp_t e;
      e.pc    = pc;
      e.plus4 = plus4;
      exp_q.push_back(e);
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #2;
   endtask

   task automatic mid();
      @(negedge CLK);
   endtask

   task automatic do_reset();
      RSTa = 1'b1;
      next_cycle();
      RSTa = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int i = 0;
      while (exp_q.size() != 0 && i < budget) begin
         @(negedge CLK);
         i++;
      end
      check("drain_empty", exp_q.size(), 0);
      next_cycle();
   endtask

   // Memory model: in-order responses, one per cycle, each due lat cycles after its grant.
   initial forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (RSTa) begin
         pend_addr.delete();
         pend_due.delete();
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
      end else if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = instr_of(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
      end
   end

   initial forever begin
      @(negedge CLK);
      if (imem_req && imem_gnt) begin
         pend_addr.push_back(imem_addr);
         pend_due.push_back(cyc + lat);
         grant_cnt++;
      end
   end

   // Monitor: every accepted head entry must match the next scoreboard entry.
   initial forever begin
      exp_t e;
      @(negedge CLK);
      if (id_valid && id_ready) begin
         if (exp_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL unexpected_pop: got pc %h expected none (cycle %0d)", id_pc, cyc);
         end else begin
            e = exp_q.pop_front();
            check("id_pc", id_pc, e.pc);
            check("id_pc_plus4", id_pc_plus4, e.plus4);
            check("id_instr", id_instr, instr_of(e.pc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int g0;

      // Reset, then continuous streaming 100/104/108 with 1-cycle memory.
      RSTa           = 1'b1;
      imem_gnt       = 1'b1;
      id_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_rvalid    = 1'b0;
      imem_rdata     = '0;
      lat            = 1;
      next_cycle();
      mid();
      check("rst_imem_req", imem_req, 0);
      check("rst_id_valid", id_valid, 0);
      check("rst_id_instr", id_instr, 0);
      check("rst_id_pc", id_pc, 0);
      check("rst_id_pc_plus4", id_pc_plus4, 0);
      next_cycle();
      RSTa = 1'b0;
      push_exp(32'h100, 32'h104);
      push_exp(32'h104, 32'h108);
      push_exp(32'h108, 32'h10C);
      mid();
      check("s1_req", imem_req, 1);
      check("s1_addr0", imem_addr, 32'h100);
      check("s1_valid0", id_valid, 0);
      next_cycle(); mid();
      check("s1_addr1", imem_addr, 32'h104);
      check("s1_valid1", id_valid, 0);
      next_cycle(); mid();
      check("s1_addr2", imem_addr, 32'h108);
      check("s1_valid2", id_valid, 1);
      next_cycle();
      imem_gnt = 1'b0;
      wait_drain(20);

      // Backpressure: exactly DEPTH grants, then drain in order.
      imem_gnt = 1'b1;
      id_ready = 1'b0;
      do_reset();
      g0 = grant_cnt;
      push_exp(32'h100, 32'h104);
      push_exp(32'h104, 32'h108);
      push_exp(32'h108, 32'h10C);
      push_exp(32'h10C, 32'h110);
      repeat (6) next_cycle();
      mid();
      check("bp_grants", grant_cnt - g0, 4);
      check("bp_req_full", imem_req, 0);
      check("bp_valid_full", id_valid, 1);
      next_cycle();
      id_ready = 1'b1;
      mid();
      check("bp_req_pop_cycle", imem_req, 0);
      next_cycle();
      imem_gnt = 1'b0;
      mid();
      check("bp_req_after_pop", imem_req, 1);
      check("bp_addr_after_pop", imem_addr, 32'h110);
      wait_drain(20);

      // Three slow responses outstanding, then redirect to 200.
      lat      = 5;
      imem_gnt = 1'b1;
      do_reset();
      mid();
      check("rd_addr0", imem_addr, 32'h100);
      next_cycle();
      next_cycle();
      next_cycle();
      imem_gnt       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      push_exp(32'h200, 32'h204);
      mid();
      check("rd_req_in_redirect", imem_req, 0);
      next_cycle();
      redirect_valid = 1'b0;
      imem_gnt       = 1'b1;
      mid();
      check("rd_req_after", imem_req, 1);
      check("rd_addr_after", imem_addr, 32'h200);
      next_cycle();
      imem_gnt = 1'b0;
      wait_drain(40);

      // Redirect coinciding with a response; unaligned target 203.
      lat      = 1;
      imem_gnt = 1'b1;
      mid();
      check("rr_addr", imem_addr, 32'h204);
      next_cycle();
      imem_gnt       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h203;
      push_exp(32'h200, 32'h204);
      mid();
      check("rr_req_in_redirect", imem_req, 0);
      next_cycle();
      redirect_valid = 1'b0;
      imem_gnt       = 1'b1;
      mid();
      check("rr_req_after", imem_req, 1);
      check("rr_addr_after", imem_addr, 32'h200);
      next_cycle();
      imem_gnt = 1'b0;
      wait_drain(20);

      // Address wrap past 32'hFFFF_FFFC.
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF8;
      push_exp(32'hFFFF_FFF8, 32'hFFFF_FFFC);
      push_exp(32'hFFFF_FFFC, 32'h0000_0000);
      push_exp(32'h0000_0000, 32'h0000_0004);
      next_cycle();
      redirect_valid = 1'b0;
      imem_gnt       = 1'b1;
      mid();
      check("wr_addr0", imem_addr, 32'hFFFF_FFF8);
      next_cycle(); mid();
      check("wr_addr1", imem_addr, 32'hFFFF_FFFC);
      next_cycle(); mid();
      check("wr_addr2", imem_addr, 32'h0000_0000);
      next_cycle();
      imem_gnt = 1'b0;
      wait_drain(20);

      // Reset mid-stream with 2 queued and 2 in flight.
      lat      = 2;
      id_ready = 1'b0;
      imem_gnt = 1'b1;
      mid();
      check("mr_addr0", imem_addr, 32'h4);
      repeat (4) next_cycle();
      RSTa     = 1'b1;
      imem_gnt = 1'b0;
      mid();
      check("mr_valid_before", id_valid, 1);
      check("mr_req_in_reset", imem_req, 0);
      next_cycle();
      RSTa = 1'b0;
      mid();
      check("mr_valid_after", id_valid, 0);
      check("mr_addr_after", imem_addr, 32'h100);
      check("mr_req_after", imem_req, 1);
`ifdef FETCH_PERF_EN
      check("mr_perf_fetched", perf_fetched, 0);
      check("mr_perf_flushed", perf_flushed, 0);
`endif
      next_cycle();
      id_ready = 1'b1;
      repeat (6) next_cycle();
      mid();
      check("mr_idle_valid", id_valid, 0);
      check("final_scoreboard", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
